ddr3_traffic_checker: RTL and testbench
=======================================

// Module: ddr3_traffic_checker
// PURPOSE
//  Parametrised Wishbone traffic generator/checker sitting between a board top and ddr3_top.
//  Issues pipelined write and read bursts over a configurable window and checks read data.
//  Adds selectable address ordering, test modes, an outstanding-request limit and fault injection.
//  Reports error/pass counts to the top for LEDs/UART.
// PARAMETERS
//  WB_ADDR_BITS    25       Wishbone burst-address width
//  WB_DATA_BITS    512      Wishbone data width (multiple of 32)
//  WB_SEL_BITS     64       byte-select width (WB_DATA_BITS/8)
//  AUX_WIDTH       16       aux tag width (>=4)
//  ADDR_START      0        first burst address of test window
//  ADDR_RANGE_BITS 10       window = 2**ADDR_RANGE_BITS bursts (<=WB_ADDR_BITS)
//  MAX_OUTSTANDING 16       max in-flight requests (2..256)
//  SEED            32'hA5A5_0F0F  data pattern seed
// PORTS
//  i_clk             in   1             controller clock
//  i_rst_n           in   1             synchronous active-low reset
//  i_calib_complete  in   1             DDR3 calibration done
//  i_start           in   1             pulse: start one pass
//  i_mode            in   2             0 seq W->R, 1 bit-reversed W->R, 2 write-only, 3 read-only
//  i_inject_fault    in   1             pulse: corrupt next issued write
//  o_wb_cyc/o_wb_stb/o_wb_we out 1 each Wishbone master controls
//  o_wb_addr         out  WB_ADDR_BITS  burst address
//  o_wb_data         out  WB_DATA_BITS  write data
//  o_wb_sel          out  WB_SEL_BITS   byte selects (all ones)
//  o_aux             out  AUX_WIDTH     {index[AUX_WIDTH-2:0], we}
//  i_wb_stall/i_wb_ack/i_wb_err in 1 each slave handshake
//  i_wb_data         in   WB_DATA_BITS  read data
//  i_aux             in   AUX_WIDTH     returned tag (ignored for checking)
//  o_busy / o_done   out  1 each        pass running / pass finished (sticky until next start)
//  o_error_count     out  32            saturating mismatch+err count
//  o_pass_count      out  32            completed passes (wraps)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, fault flag clear. Reset mid-pass drops cyc/stb same edge, no flush.
//  FSM: IDLE -> (i_start & i_calib_complete) -> WRITE (modes 0,1,2) or READ (mode 3).
//   WRITE: issue N=2**ADDR_RANGE_BITS writes; -> WAIT_WR when all issued.
//   WAIT_WR: outstanding==0 -> READ (modes 0,1) or DONE (mode 2).
//   READ: issue N reads; -> WAIT_RD; WAIT_RD: outstanding==0 -> DONE.
//   DONE: o_done=1, o_pass_count++ once, -> IDLE. i_start ignored outside IDLE.
//  Address of index i: mode 0/2/3 ADDR_START+i; mode 1 ADDR_START+bitrev(i) over ADDR_RANGE_BITS.
//  Data D(a): 32-bit word k = {a zero-extended to 32} ^ SEED ^ {k[7:0],24'h0}.
//  Handshake: request accepted when stb & !stall; stb/we/addr/data/aux held stable while stalled.
//   cyc high from first request of a phase until its last ack; low in IDLE/DONE and between phases.
//   stb deasserts when outstanding==MAX_OUTSTANDING (no new stb that cycle).
//   outstanding: +1 on accept, -1 on ack; simultaneous accept+ack -> unchanged.
//  Checking: acks return in order; read-check index counts acks in READ/WAIT_RD, compares
//   i_wb_data with D(addr(check_index)); mismatch -> error+1. i_wb_err on any ack -> error+1
//   (one increment per ack even if both). Counter saturates at 32'hFFFF_FFFF.
//  Fault: i_inject_fault sets flag; next accepted write has bit 0 inverted, flag clears on that accept.
//   Pulse during read-only pass stays pending to next write.
//  Error count cleared only by reset; persists across passes.
// TESTING
//  Mode 0, ADDR_RANGE_BITS=4, no stall -> 16 writes, 16 reads, o_error_count=0, o_pass_count=1.
//  Mode 1, range 8 -> write addr order 0,4,2,6,1,5,3,7 (+ADDR_START); 0 errors.
//  Stall high 5 cycles mid-burst -> stb/addr/data unchanged during stall; no lost or duplicate request.
//  MAX_OUTSTANDING=2, ack delay 10 cycles -> never >2 unacked; stb low while 2 outstanding.
//  i_inject_fault before write 3, mode 0 range 16 -> exactly 1 error; second pass (mode 3) -> 1 more.
//  i_rst_n low during WRITE -> cyc/stb 0 next edge, counters 0; i_start before calib -> stays IDLE.

Source files
------------

// File: rtl/ddr3_traffic_checker.sv
// ddr3_traffic_checker
//   Wishbone traffic generator/checker placed between a board top and ddr3_top.
//   A pass writes (and/or reads) 2**ADDR_RANGE_BITS bursts over a window that
//   starts at ADDR_START. Every read is checked against the address-derived
//   pattern, and the errors found are counted.
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_calib_complete          DDR3 calibration done (gates i_start)
//   i_start, i_mode           start one pass; 0 seq W->R, 1 bitrev W->R,
//                             2 write-only, 3 read-only
//   i_inject_fault            arm a bit-0 flip on the next accepted write
//   o_wb_*, o_aux             Wishbone master request side, aux = {idx, we}
//   i_wb_*, i_aux             Wishbone slave response side (i_aux unused)
//   o_busy, o_done            pass running / pass finished (sticky)
//   o_error_count             saturating mismatch + bus-error count
//   o_pass_count              completed passes (wraps)
module ddr3_traffic_checker #(
  parameter int          WB_ADDR_BITS    = 25,
  parameter int          WB_DATA_BITS    = 512,
  parameter int          WB_SEL_BITS     = 64,
  parameter int          AUX_WIDTH       = 16,
  parameter int          ADDR_START      = 0,
  parameter int          ADDR_RANGE_BITS = 10,
  parameter int          MAX_OUTSTANDING = 16,
  parameter logic [31:0] SEED            = 32'hA5A5_0F0F
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_calib_complete,
  input  logic                    i_start,
  input  logic [1:0]              i_mode,
  input  logic                    i_inject_fault,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [WB_ADDR_BITS-1:0] o_wb_addr,
  output logic [WB_DATA_BITS-1:0] o_wb_data,
  output logic [WB_SEL_BITS-1:0]  o_wb_sel,
  output logic [AUX_WIDTH-1:0]    o_aux,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  input  logic [WB_DATA_BITS-1:0] i_wb_data,
  input  logic [AUX_WIDTH-1:0]    i_aux,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_error_count,
  output logic [31:0]             o_pass_count
);
  localparam int NWORDS = WB_DATA_BITS / 32;
  localparam int CW     = ADDR_RANGE_BITS + 1;
  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] N    = CW'(1) << ADDR_RANGE_BITS;
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_WR, S_READ, S_WAIT_RD, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           cnt_q, cnt_d;      // requests presented this phase
  logic [CW-1:0]           chk_q, chk_d;      // read acks checked this pass
  logic [OW-1:0]           out_q, out_d;      // accepted but not yet acked
  logic [1:0]              mode_q, mode_d;
  logic                    flt_q, flt_d;      // fault armed
  logic                    rflt_q, rflt_d;    // presented write carries the fault
  logic                    done_q, done_d;
  logic [31:0]             err_q, err_d;
  logic [31:0]             pass_q, pass_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [WB_ADDR_BITS-1:0] addr_q, addr_d;
  logic [WB_DATA_BITS-1:0] data_q, data_d;
  logic [AUX_WIDTH-1:0]    aux_q, aux_d;

  logic unused_aux;
  assign unused_aux = ^i_aux;

  function automatic logic [WB_ADDR_BITS-1:0] idx2addr(input logic [CW-1:0] i,
                                                       input logic [1:0] m);
    logic [ADDR_RANGE_BITS-1:0] r;
    for (int b = 0; b < ADDR_RANGE_BITS; b++) r[b] = i[ADDR_RANGE_BITS-1-b];
    if (m != 2'd1) r = i[ADDR_RANGE_BITS-1:0];
    return WB_ADDR_BITS'(ADDR_START) + WB_ADDR_BITS'(r);
  endfunction

  function automatic logic [WB_DATA_BITS-1:0] pattern(input logic [WB_ADDR_BITS-1:0] a);
    logic [WB_DATA_BITS-1:0] d;
    logic [31:0]             a32;
    a32 = 32'(a);
    for (int k = 0; k < NWORDS; k++) d[32*k +: 32] = a32 ^ SEED ^ {8'(k), 24'h0};
    return d;
  endfunction

  logic acc, ack_v, rd_phase, issuing, wr_phase;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    out_d   = out_q;
    mode_d  = mode_q;
    flt_d   = flt_q;
    rflt_d  = rflt_q;
    done_d  = done_q;
    err_d   = err_q;
    pass_d  = pass_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    aux_d   = aux_q;

    acc      = stb_q & ~i_wb_stall;
    ack_v    = i_wb_ack & (out_q != '0);
    rd_phase = (state_q == S_READ) || (state_q == S_WAIT_RD);
    wr_phase = (state_q == S_WRITE);
    issuing  = wr_phase || (state_q == S_READ);

    if (acc && !ack_v)      out_d = out_q + OW'(1);
    else if (!acc && ack_v) out_d = out_q - OW'(1);

    // Arming wins over the clear so a pulse coinciding with an accept is kept.
    if (acc && rflt_q) flt_d = 1'b0;
    if (i_inject_fault) flt_d = 1'b1;

    // One increment per ack, whether it is a bus error, a mismatch or both.
    if (i_wb_ack) begin
      if (rd_phase) chk_d = chk_q + CW'(1);
      if ((i_wb_err || (rd_phase && (i_wb_data != pattern(idx2addr(chk_q, mode_q)))))
          && (err_q != 32'hFFFF_FFFF))
        err_d = err_q + 32'd1;
    end

    // Request register reloads only when nothing is presented or it was taken;
    // the limit uses next-cycle occupancy so stb never shows at the cap.
    if (!stb_q || acc) begin
      stb_d  = 1'b0;
      rflt_d = 1'b0;
      if (issuing && (cnt_q != N) && (out_d != MAXO)) begin
        stb_d  = 1'b1;
        we_d   = wr_phase;
        addr_d = idx2addr(cnt_q, mode_q);
        data_d = wr_phase ? pattern(addr_d) : '0;
        aux_d  = {(AUX_WIDTH-1)'(cnt_q), wr_phase};
        cnt_d  = cnt_q + CW'(1);
        if (wr_phase && flt_q && !(acc && rflt_q)) begin
          data_d[0] = ~data_d[0];
          rflt_d    = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: if (i_start && i_calib_complete) begin
        mode_d  = i_mode;
        cnt_d   = '0;
        chk_d   = '0;
        done_d  = 1'b0;
        state_d = (i_mode == 2'd3) ? S_READ : S_WRITE;
      end
      S_WRITE: if ((cnt_q == N) && !stb_d) state_d = S_WAIT_WR;
      S_WAIT_WR: if (out_q == '0) begin
        cnt_d   = '0;
        state_d = (mode_q == 2'd2) ? S_DONE : S_READ;
      end
      S_READ: if ((cnt_q == N) && !stb_d) state_d = S_WAIT_RD;
      S_WAIT_RD: if (out_q == '0) state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = pass_q + 32'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      chk_q  <= '0;
      out_q  <= '0;
      mode_q <= '0;
      flt_q  <= 1'b0;
      rflt_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= '0;
      pass_q <= '0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      aux_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      chk_q  <= chk_d;
      out_q  <= out_d;
      mode_q <= mode_d;
      flt_q  <= flt_d;
      rflt_q <= rflt_d;
      done_q <= done_d;
      err_q  <= err_d;
      pass_q <= pass_d;
      stb_q  <= stb_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      aux_q  <= aux_d;
    end
  end

  // cyc spans from the first presented request to the last ack of the phase.
  assign o_wb_cyc      = stb_q | (out_q != '0);
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = we_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = data_q;
  assign o_wb_sel      = '1;
  assign o_aux         = aux_q;
  assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done        = done_q;
  assign o_error_count = err_q;
  assign o_pass_count  = pass_q;
endmodule

// File: tb/tb_ddr3_traffic_checker.sv
module tb_ddr3_traffic_checker;
  localparam int AW = 12, DW = 64, SW = 8, XW = 8;
  localparam int ASTART = 32, RB = 4, MAXO = 2, N = 16;
  localparam logic [31:0] SEED = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst_n, i_calib_complete, i_start, i_inject_fault;
  logic [1:0]    i_mode;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [SW-1:0] o_wb_sel;
  logic [XW-1:0] o_aux;
  logic          i_wb_stall, i_wb_ack, i_wb_err;
  logic [DW-1:0] i_wb_data;
  logic [XW-1:0] i_aux;
  logic          o_busy, o_done;
  logic [31:0]   o_error_count, o_pass_count;

  ddr3_traffic_checker #(
    .WB_ADDR_BITS(AW), .WB_DATA_BITS(DW), .WB_SEL_BITS(SW), .AUX_WIDTH(XW),
    .ADDR_START(ASTART), .ADDR_RANGE_BITS(RB), .MAX_OUTSTANDING(MAXO), .SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_calib_complete(i_calib_complete),
    .i_start(i_start), .i_mode(i_mode), .i_inject_fault(i_inject_fault),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .o_aux(o_aux),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data), .i_aux(i_aux),
    .o_busy(o_busy), .o_done(o_done),
    .o_error_count(o_error_count), .o_pass_count(o_pass_count)
  );

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pattern: word k = address ^ SEED ^ (k << 24).
  function automatic logic [63:0] pat(input int a);
    logic [63:0] d;
    for (int k = 0; k < 2; k++) d[32*k +: 32] = 32'(a) ^ SEED ^ 32'(k << 24);
    return d;
  endfunction

  // Address of index i: linear, or bit-reversed over RB bits in mode 1.
  function automatic int exp_addr(input int m, input int i);
    int r;
    r = i;
    if (m == 1) begin
      r = 0;
      for (int b = 0; b < RB; b++) r = r * 2 + ((i >> b) & 1);
    end
    return ASTART + r;
  endfunction

  typedef struct { int a; bit we; int due; } req_t;
  req_t        pend[$];
  logic [63:0] mem [int];

  int cyc_n = 0, pcyc = 0, outst = 0, wi = 0, ri = 0, corrupt = 0, nack = 0;
  int err_exp = 0, pass_exp = 0;
  int pmode = 0, stall_mode = 0, lat_min = 1, lat_max = 1, err_ack_idx = -1;
  bit prev_st = 0;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;
  logic          prev_we;

  // Wishbone slave + scoreboard: in-order acks after random latency,
  // memory-backed read data, request order/content checks.
  initial begin
    req_t r;
    int acc, acked, ea;
    i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = '0; i_aux = '0;
    forever begin
      @(negedge clk);
      cyc_n++; pcyc++;
      if (!i_rst_n) begin
        pend.delete(); outst = 0; prev_st = 0;
        i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0;
      end else begin
        chk("cyc_rule", 64'(o_wb_cyc), 64'(o_wb_stb || (outst > 0)));
        if (outst >= MAXO) chk("stb_at_limit", 64'(o_wb_stb), 64'(0));
        if (prev_st) begin
          chk("stall_stb", 64'(o_wb_stb), 64'(1));
          chk("stall_addr", 64'(o_wb_addr), 64'(prev_a));
          chk("stall_data", o_wb_data, prev_d);
          chk("stall_we", 64'(o_wb_we), 64'(prev_we));
        end
        case (stall_mode)
          1:       i_wb_stall = ($urandom_range(0, 2) == 0);
          2:       i_wb_stall = (pcyc >= 8) && (pcyc < 13);
          default: i_wb_stall = 0;
        endcase
        i_wb_ack = 0; i_wb_err = 0; acked = 0;
        if (pend.size() > 0 && pend[0].due <= cyc_n) begin
          r = pend.pop_front();
          acked = 1; i_wb_ack = 1;
          i_wb_err = (nack == err_ack_idx);
          nack++;
          i_wb_data = mem.exists(r.a) ? mem[r.a] : '0;
          if (i_wb_err || (!r.we && i_wb_data !== pat(r.a))) err_exp++;
        end
        acc = 0;
        if (o_wb_stb && !i_wb_stall) begin
          acc = 1;
          chk("req_we", 64'(o_wb_we), 64'((pmode != 3) && (wi < N)));
          if (o_wb_we) begin
            ea = exp_addr(pmode, wi);
            chk("wr_addr", 64'(o_wb_addr), 64'(ea));
            chk("wr_aux", 64'(o_aux), 64'(wi * 2 + 1));
            if (o_wb_data === (pat(ea) ^ 64'd1)) corrupt++;
            else chk("wr_data", o_wb_data, pat(ea));
            mem[int'(o_wb_addr)] = o_wb_data;
            pend.push_back('{int'(o_wb_addr), 1'b1, cyc_n + $urandom_range(lat_min, lat_max)});
            wi++;
          end else begin
            ea = exp_addr(pmode, ri);
            chk("rd_addr", 64'(o_wb_addr), 64'(ea));
            chk("rd_aux", 64'(o_aux), 64'(ri * 2));
            pend.push_back('{int'(o_wb_addr), 1'b0, cyc_n + $urandom_range(lat_min, lat_max)});
            ri++;
          end
        end
        outst = outst + acc - acked;
        prev_st = o_wb_stb && i_wb_stall;
        prev_a = o_wb_addr; prev_d = o_wb_data; prev_we = o_wb_we;
      end
    end
  end

  task automatic run_pass(input int m, input bit inj);
    int t;
    pmode = m; wi = 0; ri = 0; corrupt = 0; nack = 0; pcyc = 0;
    @(negedge clk); i_mode = 2'(m); i_start = 1;
    @(negedge clk); i_start = 0;
    if (inj) begin
      repeat (2) @(negedge clk);
      i_inject_fault = 1;
      @(negedge clk); i_inject_fault = 0;
    end
    t = 0;
    while (!o_done && t < 5000) begin @(negedge clk); t++; end
    chk("done_timeout", 64'(t < 5000), 64'(1));
    pass_exp++;
    chk("pass_count", 64'(o_pass_count), 64'(pass_exp));
    chk("err_count", 64'(o_error_count), 64'(err_exp));
    chk("wr_issued", 64'(wi), 64'((m == 3) ? 0 : N));
    chk("rd_issued", 64'(ri), 64'((m == 2) ? 0 : N));
    chk("busy_after", 64'(o_busy), 64'(0));
    chk("cyc_after", 64'(o_wb_cyc), 64'(0));
  endtask

  initial begin
    i_rst_n = 0; i_calib_complete = 0; i_start = 0; i_mode = 0; i_inject_fault = 0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 64'(o_wb_cyc), 64'(0));
    chk("rst_stb", 64'(o_wb_stb), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_err", 64'(o_error_count), 64'(0));
    chk("rst_pass", 64'(o_pass_count), 64'(0));
    i_rst_n = 1;

    // Start without calibration is ignored.
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    repeat (4) @(negedge clk);
    chk("nocal_busy", 64'(o_busy), 64'(0));
    chk("nocal_stb", 64'(o_wb_stb), 64'(0));
    i_calib_complete = 1;

    // A: sequential, no stall, single-cycle ack
    stall_mode = 0; lat_min = 1; lat_max = 1;
    run_pass(0, 0);
    chk("A_err", 64'(o_error_count), 64'(0));
    chk("A_done", 64'(o_done), 64'(1));

    // B: bit-reversed, random stall and latency
    stall_mode = 1; lat_min = 1; lat_max = 4;
    run_pass(1, 0);
    chk("B_err", 64'(o_error_count), 64'(0));

    // C: fault injected early in a W->R pass
    stall_mode = 1; lat_min = 1; lat_max = 10;
    run_pass(0, 1);
    chk("C_corrupt", 64'(corrupt), 64'(1));
    chk("C_err", 64'(o_error_count), 64'(1));

    // D: read-only, ack delay 10 against the outstanding cap
    stall_mode = 0; lat_min = 10; lat_max = 10;
    run_pass(3, 0);
    chk("D_err", 64'(o_error_count), 64'(2));

    // E: write-only, 5-cycle stall mid-burst, one bus error
    stall_mode = 2; lat_min = 1; lat_max = 3; err_ack_idx = 5;
    run_pass(2, 0);
    err_ack_idx = -1;
    chk("E_err", 64'(o_error_count), 64'(3));

    // F: fault armed during read-only pass stays pending
    stall_mode = 1; lat_min = 1; lat_max = 5;
    run_pass(3, 1);
    chk("F_corrupt", 64'(corrupt), 64'(0));
    chk("F_err", 64'(o_error_count), 64'(3));

    // G: the pending fault lands on this write pass
    run_pass(2, 0);
    chk("G_corrupt", 64'(corrupt), 64'(1));

    // Reset during WRITE
    pmode = 0; wi = 0; ri = 0;
    @(negedge clk); i_mode = 0; i_start = 1;
    @(negedge clk); i_start = 0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 64'(o_busy), 64'(1));
    i_rst_n = 0;
    @(negedge clk);
    chk("midrst_cyc", 64'(o_wb_cyc), 64'(0));
    chk("midrst_stb", 64'(o_wb_stb), 64'(0));
    chk("midrst_err", 64'(o_error_count), 64'(0));
    chk("midrst_pass", 64'(o_pass_count), 64'(0));
    chk("midrst_busy", 64'(o_busy), 64'(0));
    err_exp = 0; pass_exp = 0;
    @(negedge clk); i_rst_n = 1;

    // H: clean W->R after reset
    stall_mode = 1; lat_min = 1; lat_max = 6;
    run_pass(0, 0);
    chk("H_err", 64'(o_error_count), 64'(0));
    chk("H_pass", 64'(o_pass_count), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
